// File: rtl/flip_flop_d1_if.sv
// Data bundle for the single-stage display-datapath register.
// Latency: none; this only groups the captured and registered data.
// Backpressure: none; data is sampled on every clock edge.
interface flip_flop_d1_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  // Driver side presents d and observes q.
  modport master (output d, input q);
  // Register side captures d and drives q.
  modport slave (input d, output q);
endinterface

// File: rtl/flip_flop_d1.sv
// Positive-edge D register with synchronous active-high reset to RST_VAL.
// Latency: one cycle; q shows the d sampled at the previous rising edge.
// Backpressure: none; d is captured unconditionally on every edge.
module flip_flop_d1 #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  flip_flop_d1_if.slave bus
);

  // Declaration initialiser sets the power-up value, so q already equals
  // RST_VAL before the first edge in simulation and in the FPGA bitstream.
  logic [WIDTH-1:0] q_r = RST_VAL;

  // Capture d each edge; reset wins over d and only acts on an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= RST_VAL;
    end else begin
      q_r <= bus.d;
    end
  end

  // q comes straight from the flop: no combinational path from d or rst.
  assign bus.q = q_r;

endmodule

// File: tb/tb_flip_flop_d1.sv
module tb_flip_flop_d1;

  logic clk = 1'b0;
  logic rst1;
  logic rstw;

  flip_flop_d1_if #(.WIDTH(1)) bus1 ();
  flip_flop_d1_if #(.WIDTH(8)) busw ();

  flip_flop_d1 #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1.slave)
  );

  flip_flop_d1 #(.WIDTH(8), .RST_VAL(8'hA5)) dutw (
    .clk (clk),
    .rst (rstw),
    .bus (busw.slave)
  );

  // 10 ns period, first rising edge at 5 ns.
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       exp1_q[$];
  logic [7:0] expw_q[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Directed vectors, one per cycle, applied between edges (t = 10*k).
  // Expected q values after edge 5+10*k are hand-computed.
  localparam int N = 10;
  logic       v_d1  [N] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic       v_r1  [N] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic       v_q1  [N] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [7:0] v_dw  [N] = '{8'h3C, 8'h3C, 8'hFF, 8'h00, 8'h5A, 8'hC3, 8'hC3, 8'h81, 8'h7E, 8'h01};
  logic       v_rw  [N] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [7:0] v_qw  [N] = '{8'h3C, 8'hA5, 8'hFF, 8'h00, 8'h5A, 8'hA5, 8'hA5, 8'h81, 8'h7E, 8'h01};

  // Monitor: after every rising edge, pop the expected value and compare.
  initial begin
    logic       e1;
    logic [7:0] ew;
    forever begin
      @(posedge clk);
      #1;
      if (exp1_q.size() > 0) begin
        e1 = exp1_q.pop_front();
        check("q_w1", {7'b0, bus1.q}, {7'b0, e1});
      end
      if (expw_q.size() > 0) begin
        ew = expw_q.pop_front();
        check("q_w8", busw.q, ew);
      end
    end
  end

  // Stimulus: drive each vector, queue its expected response.
  initial begin
    for (int k = 0; k < N; k++) begin
      bus1.d = v_d1[k];
      rst1   = v_r1[k];
      busw.d = v_dw[k];
      rstw   = v_rw[k];
      exp1_q.push_back(v_q1[k]);
      expw_q.push_back(v_qw[k]);
      if (k == 0) begin
        // Power-up value visible before the first edge.
        #1;
        check("powerup_w1", {7'b0, bus1.q}, 8'h00);
        check("powerup_w8", busw.q, 8'hA5);
      end else if (k == 4) begin
        // Glitch on d between edges must not reach q.
        #1 bus1.d = 1'b0;
        #1 check("glitch_mid", {7'b0, bus1.q}, 8'h00);
        #1 bus1.d = 1'b1;
        #1 check("glitch_end", {7'b0, bus1.q}, 8'h00);
      end else if (k == 6) begin
        // Reset raised between edges has no effect until the next edge.
        #2;
        check("sync_rst_hold", {7'b0, bus1.q}, 8'h01);
      end
      @(negedge clk);
    end
    @(negedge clk);
    @(negedge clk);
    check("queue1_drained", 8'(exp1_q.size()), 8'd0);
    check("queuew_drained", 8'(expw_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #10000;
    $display("FAIL timeout at %0t: simulation did not complete, expected finish by 10000", $time);
    $fatal(1, "timeout");
  end

endmodule
